// File: rtl/net_lane_sender.sv
// net_lane_sender: multi-lane serial frame transmitter with stop-and-wait retransmission.
// A payload snapshot is split across LANES serial lines. Each lane sends
// SYNCWORD, the sequence bit and its payload slice, MSB first.
// The sender then waits for a matching ACK and retransmits on timeout.
// Optional feature macro: NET_LANE_PARITY_EN appends one even-parity bit per lane.
// The parity bit covers the sequence bit and the slice.
module net_lane_sender #(
  parameter int                   LANES          = 4,
  parameter int                   PAYLOAD_BITS   = 832,
  parameter int                   SYNC_BITS      = 8,
  parameter logic [SYNC_BITS-1:0] SYNCWORD       = 8'hA7,
  parameter int                   BIT_DIV        = 4,
  parameter int                   TIMEOUT_CYCLES = 200,
  parameter int                   MAX_RETRIES    = 3
) (
  input  logic                             clk,
  input  logic                             rst_l,
  input  logic                             game_active,
  input  logic                             load,
  input  logic [PAYLOAD_BITS-1:0]          payload_in,
  input  logic                             ack_valid,
  input  logic                             ack_seq,
  output logic [LANES-1:0]                 serial_out,
  output logic                             busy,
  output logic                             tx_seq,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic                             link_fail
);

  localparam int LANE_BITS  = (PAYLOAD_BITS + LANES - 1) / LANES;
`ifdef NET_LANE_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int FRAME_BITS = SYNC_BITS + 1 + LANE_BITS + PAR_BITS;
  localparam int LANE_TOTAL = LANES * LANE_BITS;
  localparam int PAD_BITS   = LANE_TOTAL - PAYLOAD_BITS;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = $clog2(BIT_DIV + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W       = $clog2(MAX_RETRIES + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] FAIL     = 2'd3;

  logic [1:0]              state;
  logic                    pending;
  logic [PAYLOAD_BITS-1:0] buffer;
  logic [PAYLOAD_BITS-1:0] frame_data;
  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        bit_pos;
  logic [TO_W-1:0]         to_cnt;
  logic [LANE_TOTAL-1:0]   padded;
  logic                    ack_match;
  logic                    have_data;
  logic                    start;

`ifdef NET_LANE_PARITY_EN
  // Even parity over the sequence bit and the lane slice.
  function automatic logic even_parity(input logic seq, input logic [LANE_BITS-1:0] slice);
    return seq ^ (^slice);
  endfunction
`endif

  assign ack_match = ack_valid && (ack_seq == tx_seq);
  assign have_data = pending || load;
  // A new frame starts from IDLE, or straight out of WAIT_ACK after a good ACK.
  assign start     = game_active && have_data &&
                     ((state == IDLE) || ((state == WAIT_ACK) && ack_match));

  // The last lane is zero-padded in its LSBs when the payload does not divide evenly.
  assign padded = LANE_TOTAL'(frame_data) << PAD_BITS;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_BITS-1:0]  slice;
    logic [FRAME_BITS-1:0] frame;
    assign slice = padded[LANE_TOTAL-1-i*LANE_BITS -: LANE_BITS];
`ifdef NET_LANE_PARITY_EN
    assign frame = {SYNCWORD, tx_seq, slice, even_parity(tx_seq, slice)};
`else
    assign frame = {SYNCWORD, tx_seq, slice};
`endif
    // bit_pos counts down, so the frame leaves MSB first.
    assign serial_out[i] = (state == SEND) && frame[bit_pos];
  end

  assign busy      = (state == SEND) || (state == WAIT_ACK);
  assign link_fail = (state == FAIL);

  // Payload storage: latest load wins; the in-flight copy only changes when a frame starts.
  always_ff @(posedge clk) begin
    if (game_active && load) buffer <= payload_in;
    if (start) frame_data <= load ? payload_in : buffer;
  end

  // Control FSM: send, wait for ACK, retry on timeout, fail after the retry budget.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state       <= IDLE;
      pending     <= 1'b0;
      tx_seq      <= 1'b0;
      retry_count <= '0;
      div_cnt     <= '0;
      bit_pos     <= '0;
      to_cnt      <= '0;
    end else if (!game_active) begin
      state       <= IDLE;
      pending     <= 1'b0;
      tx_seq      <= 1'b0;
      retry_count <= '0;
    end else begin
      if (load) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= SEND;
            pending     <= 1'b0;
            retry_count <= '0;
            div_cnt     <= '0;
            bit_pos     <= IDX_W'(FRAME_BITS - 1);
          end
        end
        SEND: begin
          if (div_cnt == DIV_W'(BIT_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_pos == '0) begin
              state  <= WAIT_ACK;
              to_cnt <= '0;
            end else begin
              bit_pos <= bit_pos - IDX_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        WAIT_ACK: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (ack_match) begin
            tx_seq      <= ~tx_seq;
            retry_count <= '0;
            if (have_data) begin
              state   <= SEND;
              pending <= 1'b0;
              div_cnt <= '0;
              bit_pos <= IDX_W'(FRAME_BITS - 1);
            end else begin
              state <= IDLE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            if (retry_count == RC_W'(MAX_RETRIES)) begin
              state <= FAIL;
            end else begin
              retry_count <= retry_count + RC_W'(1);
              state       <= SEND;
              div_cnt     <= '0;
              bit_pos     <= IDX_W'(FRAME_BITS - 1);
            end
          end
        end
        FAIL: begin
          state <= FAIL;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_net_lane_sender.sv
// Testbench for net_lane_sender: directed stimulus with a frame scoreboard.
// The bench configuration is 2 lanes, 16-bit payload, 4-bit syncword 1011,
// 1 clk per bit, a timeout of 10 cycles and 2 retries.
// Expected lane frames are pushed when stimulus is issued. A monitor
// reassembles each transmitted frame and pops from the queue to compare.
module tb_net_lane_sender;

  logic        clk;
  logic        rst_l;
  logic        game_active;
  logic        load;
  logic [15:0] payload_in;
  logic        ack_valid;
  logic        ack_seq;
  logic [1:0]  serial_out;
  logic        busy;
  logic        tx_seq;
  logic [1:0]  retry_count;
  logic        link_fail;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected frames as {lane0 frame, lane1 frame}. Each frame is 13 bits, first-sent bit is the MSB.
  logic [25:0] sb[$];

  localparam logic [25:0] F_A55A_S0 = {13'b1011_0_10100101, 13'b1011_0_01011010};
  localparam logic [25:0] F_C3E1_S0 = {13'b1011_0_11000011, 13'b1011_0_11100001};
  localparam logic [25:0] F_2222_S1 = {13'b1011_1_00100010, 13'b1011_1_00100010};

  net_lane_sender #(
    .LANES(2), .PAYLOAD_BITS(16), .SYNC_BITS(4), .SYNCWORD(4'b1011),
    .BIT_DIV(1), .TIMEOUT_CYCLES(10), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .rst_l(rst_l), .game_active(game_active), .load(load),
    .payload_in(payload_in), .ack_valid(ack_valid), .ack_seq(ack_seq),
    .serial_out(serial_out), .busy(busy), .tx_seq(tx_seq),
    .retry_count(retry_count), .link_fail(link_fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Status vector: {serial_out[1], serial_out[0], busy, tx_seq, retry_count[1:0], link_fail}.
  task automatic chk_st(input string name, input logic [6:0] exp);
    chk(name, {25'd0, serial_out, busy, tx_seq, retry_count, link_fail}, {25'd0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame monitor: starts on the first non-zero lane sample while busy.
  // It collects 13 samples per lane. A frame cut short by busy dropping is discarded.
  int          nbits = 0;
  logic [12:0] cap0, cap1;
  logic [25:0] exp_frame;
  initial begin
    forever begin
      @(negedge clk);
      if (nbits == 0) begin
        if (busy && serial_out != 2'b00) begin
          cap0  = {12'd0, serial_out[0]};
          cap1  = {12'd0, serial_out[1]};
          nbits = 1;
        end
      end else if (!busy) begin
        nbits = 0;
      end else begin
        cap0  = {cap0[11:0], serial_out[0]};
        cap1  = {cap1[11:0], serial_out[1]};
        nbits = nbits + 1;
      end
      if (nbits == 13) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: got %0h expected no frame", {cap0, cap1});
        end else begin
          exp_frame = sb.pop_front();
          chk("frame", {6'd0, cap0, cap1}, {6'd0, exp_frame});
        end
        nbits = 0;
      end
    end
  end

  // Directed stimulus; inputs change on the falling edge, outputs are read there too.
  initial begin
    rst_l = 1'b0; game_active = 1'b0; load = 1'b0; payload_in = '0;
    ack_valid = 1'b0; ack_seq = 1'b0;
    step(3);
    chk_st("reset_state", 7'b00_0_0_00_0);
    rst_l = 1'b1; game_active = 1'b1;
    step(2);
    chk_st("idle_after_reset", 7'b00_0_0_00_0);

    // Basic frame and ACK handling.
    load = 1'b1; payload_in = 16'hA55A; sb.push_back(F_A55A_S0);
    step(1); load = 1'b0;
    chk_st("basic_first_bit", 7'b11_1_0_00_0);
    step(12);
    chk_st("basic_last_bit", 7'b01_1_0_00_0);
    step(1);
    chk_st("basic_wait_ack", 7'b00_1_0_00_0);
    ack_valid = 1'b1; ack_seq = 1'b1;
    step(1); ack_valid = 1'b0;
    chk_st("ack_mismatch_ignored", 7'b00_1_0_00_0);
    ack_valid = 1'b1; ack_seq = 1'b0;
    step(1); ack_valid = 1'b0;
    chk_st("ack_match_idle", 7'b00_0_1_00_0);

    // Dropping game_active clears tx_seq; a load while inactive is ignored.
    game_active = 1'b0; load = 1'b1; payload_in = 16'hBEEF;
    step(1); load = 1'b0; game_active = 1'b1;
    chk_st("inactive_clears_seq", 7'b00_0_0_00_0);
    step(2);
    chk_st("load_ignored_inactive", 7'b00_0_0_00_0);

    // Retries then link failure.
    load = 1'b1; payload_in = 16'hA55A;
    sb.push_back(F_A55A_S0); sb.push_back(F_A55A_S0); sb.push_back(F_A55A_S0);
    step(1); load = 1'b0;
    chk_st("retry_first_send", 7'b11_1_0_00_0);
    step(22);
    chk_st("retry_wait_end", 7'b00_1_0_00_0);
    step(1);
    chk_st("retry1_resend", 7'b11_1_0_01_0);
    step(23);
    chk_st("retry2_resend", 7'b11_1_0_10_0);
    step(22);
    chk_st("last_wait", 7'b00_1_0_10_0);
    step(1);
    chk_st("link_fail_set", 7'b00_0_0_10_1);
    load = 1'b1; payload_in = 16'hFFFF;
    step(1); load = 1'b0;
    chk_st("fail_holds", 7'b00_0_0_10_1);
    game_active = 1'b0;
    step(1);
    chk_st("fail_cleared", 7'b00_0_0_00_0);
    game_active = 1'b1;
    step(3);
    chk_st("pending_cleared", 7'b00_0_0_00_0);

    // Overwrite during SEND; the latest load is sent next with seq 1.
    load = 1'b1; payload_in = 16'hC3E1; sb.push_back(F_C3E1_S0);
    step(1); load = 1'b0;
    step(2); load = 1'b1; payload_in = 16'h1111;
    step(1); payload_in = 16'h2222;
    step(1); load = 1'b0;
    step(9);
    chk_st("ovw_wait_ack", 7'b00_1_0_00_0);
    ack_valid = 1'b1; ack_seq = 1'b0;
    sb.push_back(F_2222_S1); sb.push_back(F_2222_S1);
    step(1); ack_valid = 1'b0;
    chk_st("ovw_next_frame", 7'b11_1_1_00_0);
    step(23);
    chk_st("ovw_resend", 7'b11_1_1_01_0);
    step(14);
    chk_st("ovw_wait_retry", 7'b00_1_1_01_0);

    // Reset in the middle of WAIT_ACK.
    rst_l = 1'b0;
    step(1);
    chk_st("reset_mid_wait", 7'b00_0_0_00_0);
    rst_l = 1'b1;
    step(1);

    // Abort at frame bit 5.
    load = 1'b1; payload_in = 16'h0F0F;
    step(1); load = 1'b0;
    chk_st("abort_first_bit", 7'b11_1_0_00_0);
    step(5);
    game_active = 1'b0;
    step(1);
    chk_st("abort_idle", 7'b00_0_0_00_0);
    game_active = 1'b1;
    step(3);
    chk_st("abort_stays_idle", 7'b00_0_0_00_0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/net_lane_sender.md
Name: net_lane_sender

Overview:
- Parametrised multi-lane serial frame transmitter with stop-and-wait retransmission.
- Takes a wide game-state payload snapshot and splits it across LANES serial data lines. Each lane frame carries a syncword, a sequence bit and a payload slice.
- After sending, waits for a matching ACK; retransmits on timeout up to MAX_RETRIES times, then flags link failure.
- Sits between game logic and GPIO pins. Replaces the fixed 4-lane data sender path with generic lane count, width and bit rate.

Parameters:
- LANES, 4: number of serial data lanes.
- PAYLOAD_BITS, 832: total payload width.
- SYNC_BITS, 8: syncword width.
- SYNCWORD, 8'hA7: syncword value, sent MSB first.
- BIT_DIV, 4: clk cycles per serial bit (must be ≥1).
- TIMEOUT_CYCLES, 200: clk cycles in WAIT_ACK before a retry.
- MAX_RETRIES, 3: retransmissions allowed before failure.
- Derived: LANE_BITS = ceil(PAYLOAD_BITS/LANES); FRAME_BITS = SYNC_BITS+1+LANE_BITS (+1 with parity).

Ports:
- clk  in  1  single clock.
- rst_l  in  1  synchronous active-low reset.
- game_active  in  1  enable; low aborts all activity.
- load  in  1  1-cycle pulse, payload_in valid.
- payload_in  in  PAYLOAD_BITS  game-state snapshot.
- ack_valid  in  1  1-cycle pulse, ACK received.
- ack_seq  in  1  sequence bit carried by the ACK.
- serial_out  out  LANES  serial lane outputs, idle 0.
- busy  out  1  state is SEND or WAIT_ACK.
- tx_seq  out  1  sequence bit of the current or next frame.
- retry_count  out  $clog2(MAX_RETRIES+1)  retries used on the current frame.
- link_fail  out  1  retries exhausted.

Behaviour:
- Reset: evaluated on posedge clk with rst_l low. Every output resets to 0; state IDLE; pending cleared; tx_seq 0. Reset mid-frame aborts immediately; serial_out is 0 on the next cycle.
- Pending buffer, one deep:
  - load stores payload_in and sets pending.
  - A later load overwrites the buffer (latest wins); no backpressure.
  - The frame currently in flight is held in a separate register and never changes mid-transmission.
- Lane split:
  - Lane 0 carries payload MSBs; lane i carries bits [PAYLOAD_BITS-1-i*LANE_BITS -: LANE_BITS].
  - The last lane is zero-padded in its LSBs when PAYLOAD_BITS is not a multiple of LANES.
- Frame per lane, sent MSB first: SYNCWORD, then tx_seq, then lane slice.
- IDLE:
  - Exit condition: game_active && pending.
  - Action: copy buffer to the frame register, clear pending, retry_count←0, go to SEND.
  - If load occurs in the same cycle, the new payload is used (bypass).
- SEND:
  - From the cycle after entry, serial_out holds frame bit k for exactly BIT_DIV cycles, k = 0..FRAME_BITS-1. All lanes advance in lockstep.
  - After the last bit: serial_out←0, go to WAIT_ACK, timeout counter←0.
  - ack_valid during SEND is ignored.
- WAIT_ACK: counter increments each cycle.
  - ack_valid && ack_seq==tx_seq: toggle tx_seq, retry_count←0. If pending, start the next frame as in IDLE; else go to IDLE. An ACK on the same cycle as timeout takes priority.
  - ack_valid with a mismatched ack_seq: ignored.
  - Counter reaches TIMEOUT_CYCLES with retry_count<MAX_RETRIES: retry_count++, resend the same frame and same seq (go to SEND).
  - Counter reaches TIMEOUT_CYCLES with retry_count==MAX_RETRIES: go to FAIL.
- FAIL:
  - link_fail=1; serial_out=0.
  - load still updates the buffer.
  - Leaves only when game_active goes low; then go to IDLE, link_fail←0, tx_seq←0.
- game_active low in any state:
  - Next state IDLE; pending cleared; serial_out 0; tx_seq←0; retry_count←0.
  - load is ignored while game_active is low.

Optional Feature:
- Macro: NET_LANE_PARITY_EN.
- Defined: each lane appends one even-parity bit after its payload slice, computed over the seq bit and slice (syncword excluded). FRAME_BITS increases by 1.
- Undefined: no parity bit; the frame ends at the slice LSB.

Test Plan:
Bench parameters for all scenarios: LANES=2, PAYLOAD_BITS=16, SYNC_BITS=4, SYNCWORD=4'b1011, BIT_DIV=1, TIMEOUT_CYCLES=10, MAX_RETRIES=2, parity off.
- Basic frame: game_active=1, load 16'hA55A at T.
  - serial_out[0] over T+1..T+13 = 1011_0_10100101.
  - serial_out[1] over the same cycles = 1011_0_01011010.
  - busy=1 from T+1.
- ACK matching: ack_valid with ack_seq=0 during WAIT_ACK → tx_seq=1, IDLE, busy=0. A prior ack_seq=1 pulse leaves the state unchanged.
- Retry and fail: no ACK.
  - Resend starts 10 cycles after WAIT_ACK entry, with an identical frame and seq 0; retry_count goes 1 then 2.
  - The third timeout sets link_fail=1.
  - game_active low clears link_fail on the next cycle.
- Overwrite: during SEND, load 16'h1111 then 16'h2222.
  - The in-flight frame is unchanged.
  - After the matching ACK, the next frame carries 16'h2222 with seq 1.
- Abort and reset: drop game_active at frame bit 5 → serial_out=0 and IDLE next cycle. Separately, rst_l low mid-WAIT_ACK → all outputs 0.
- With NET_LANE_PARITY_EN defined: payload 16'hA55A gives a 14-bit frame; lane 0 trailing bit=0 (seq 0 plus 4 ones in A5 is even).
